// File: rtl/ws2812b_pkg.sv
// Shared types and default timing for the WS2812B serializer.
// Timing defaults assume a 20 MHz clk.
// No ports; imported by ws2812b_serializer and ws2812b_bit_timer.
package ws2812b_pkg;

  localparam int PIXEL_BITS = 24;

  // 20 MHz defaults: 0.40 us, 0.80 us, 1.25 us, 300 us
  localparam int T0H_CYCLES_DEF   = 8;
  localparam int T1H_CYCLES_DEF   = 16;
  localparam int BIT_CYCLES_DEF   = 25;
  localparam int RESET_CYCLES_DEF = 6000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } state_t;

endpackage

// File: rtl/ws2812b_bit_timer.sv
// Cycle counter for one WS2812B bit period, reused to time the latch period.
// Latency: end flags are combinational decodes of the registered count.
// Backpressure: none; the owning FSM decides when to clear and when to count.
// Ports: clk, reset (async, active-high), clr (restart at 0, wins over en),
//        en (count up), bit_val (bit being sent), high_end (last high cycle),
//        bit_end (last cycle of the bit period), latch_end (last latch cycle).
module ws2812b_bit_timer #(
  parameter int T0H_CYCLES   = 8,
  parameter int T1H_CYCLES   = 16,
  parameter int BIT_CYCLES   = 25,
  parameter int RESET_CYCLES = 6000,
  parameter int CNT_W        = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic bit_val,
  output logic high_end,
  output logic bit_end,
  output logic latch_end
);

  localparam logic [CNT_W-1:0] T0H_LAST   = CNT_W'(T0H_CYCLES - 1);
  localparam logic [CNT_W-1:0] T1H_LAST   = CNT_W'(T1H_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The count runs across the whole bit, so the high phase ends at the
  // bit-dependent width and the bit ends at a fixed period.
  assign high_end  = (cnt == (bit_val ? T1H_LAST : T0H_LAST));
  assign bit_end   = (cnt == BIT_LAST);
  assign latch_end = (cnt == RESET_LAST);

endmodule

// File: rtl/ws2812b_serializer.sv
// WS2812B single-wire serializer: one 24-bit pixel per valid/ready handshake, MSB first.
// Latency: led rises the cycle after accept; a pixel takes 24*BIT_CYCLES cycles, plus RESET_CYCLES if latched.
// Backpressure: ready is registered; without WS2812B_DOUBLE_BUFFER_EN it is high only in IDLE,
//   with WS2812B_DOUBLE_BUFFER_EN it is !hold_full (one pixel queued behind the shifter).
// Ports: clk, reset (async, active-high), data_in[23:0], valid, latch -> ready, led.
module ws2812b_serializer
  import ws2812b_pkg::*;
#(
  parameter int T0H_CYCLES   = T0H_CYCLES_DEF,
  parameter int T1H_CYCLES   = T1H_CYCLES_DEF,
  parameter int BIT_CYCLES   = BIT_CYCLES_DEF,
  parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PIXEL_BITS-1:0] data_in,
  input  logic                  valid,
  input  logic                  latch,
  output logic                  ready,
  output logic                  led
);

  localparam int CNT_W = $clog2(RESET_CYCLES + 1);
  localparam int BIT_W = $clog2(PIXEL_BITS);

  state_t                state, state_nxt;
  logic [PIXEL_BITS-1:0] shift;
  logic                  latch_q;
  logic [BIT_W-1:0]      bit_cnt;

  logic accept, load_in, load_hold, shift_en, next_pixel;
  logic tmr_clr, tmr_en, high_end, bit_end, latch_end;
  logic ready_nxt;
  logic [PIXEL_BITS-1:0] nxt_data;
  logic                  nxt_latch;

  assign accept = valid & ready;

  ws2812b_bit_timer #(
    .T0H_CYCLES  (T0H_CYCLES),
    .T1H_CYCLES  (T1H_CYCLES),
    .BIT_CYCLES  (BIT_CYCLES),
    .RESET_CYCLES(RESET_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .bit_val  (shift[PIXEL_BITS-1]),
    .high_end (high_end),
    .bit_end  (bit_end),
    .latch_end(latch_end)
  );

`ifdef WS2812B_DOUBLE_BUFFER_EN
  logic [PIXEL_BITS-1:0] hold_data;
  logic                  hold_latch;
  logic                  hold_full, hold_full_nxt;
`endif

  always_comb begin
    state_nxt  = state;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    load_in    = 1'b0;
    load_hold  = 1'b0;
    shift_en   = 1'b0;
    next_pixel = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load_in   = 1'b1;
          tmr_clr   = 1'b1;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        tmr_en = 1'b1;
        if (high_end) state_nxt = LOW;
      end
      LOW: begin
        tmr_en = 1'b1;
        if (bit_end) begin
          tmr_clr = 1'b1;
          if (bit_cnt != BIT_W'(PIXEL_BITS - 1)) begin
            shift_en  = 1'b1;
            state_nxt = HIGH;
          end else if (latch_q) begin
            state_nxt = LATCH;
          end else begin
            next_pixel = 1'b1;
          end
        end
      end
      LATCH: begin
        tmr_en = 1'b1;
        if (latch_end) begin
          tmr_clr    = 1'b1;
          next_pixel = 1'b1;
        end
      end
    endcase

    // Pixel boundary: with a queued pixel the next bit starts on this edge,
    // keeping rising edges exactly one bit period apart.
    if (next_pixel) begin
`ifdef WS2812B_DOUBLE_BUFFER_EN
      if (hold_full) begin
        load_hold = 1'b1;
        state_nxt = HIGH;
      end else if (accept) begin
        load_in   = 1'b1;
        state_nxt = HIGH;
      end else begin
        state_nxt = IDLE;
      end
`else
      state_nxt = IDLE;
`endif
    end
  end

`ifdef WS2812B_DOUBLE_BUFFER_EN
  // An accept that does not go straight into the shifter parks in the hold
  // register; ready is low whenever it is full, so it is never overwritten.
  always_comb begin
    hold_full_nxt = hold_full;
    if (load_hold) hold_full_nxt = 1'b0;
    if (accept && !load_in) hold_full_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data  <= '0;
      hold_latch <= 1'b0;
      hold_full  <= 1'b0;
    end else begin
      hold_full <= hold_full_nxt;
      if (accept && !load_in) begin
        hold_data  <= data_in;
        hold_latch <= latch;
      end
    end
  end

  assign nxt_data  = load_hold ? hold_data  : data_in;
  assign nxt_latch = load_hold ? hold_latch : latch;
  assign ready_nxt = !hold_full_nxt;
`else
  assign nxt_data  = data_in;
  assign nxt_latch = latch;
  assign ready_nxt = (state_nxt == IDLE);
`endif

  // Reset lands in LATCH so the strip always sees a full latch period first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LATCH;
      led   <= 1'b0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      led   <= (state_nxt == HIGH);
      ready <= ready_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift   <= '0;
      latch_q <= 1'b0;
      bit_cnt <= '0;
    end else if (load_in || load_hold) begin
      shift   <= nxt_data;
      latch_q <= nxt_latch;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shift   <= {shift[PIXEL_BITS-2:0], 1'b0};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ws2812b_serializer.sv
// Self-checking bench for ws2812b_serializer.
// Expected line waveforms come from the bit-timing rules (high 16/8 cycles in a
// 25-cycle period, 6000-cycle latch), never from the design's internals.
module tb_ws2812b_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] data_in = '0;
  logic        valid = 1'b0;
  logic        latch = 1'b0;
  logic        ready;
  logic        led;

  int n_tests = 0;
  int n_fail  = 0;
  int last_w[24];

  always #5 clk = ~clk;

  ws2812b_serializer dut (
    .clk    (clk),
    .reset  (reset),
    .data_in(data_in),
    .valid  (valid),
    .latch  (latch),
    .ready  (ready),
    .led    (led)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Line level j cycles after the accept edge for pixel d (0 after 24 bits).
  function automatic logic model_led(input logic [23:0] d, input int j);
    int b;
    b = j / 25;
    if (b >= 24) return 1'b0;
    return ((j % 25) < (d[23-b] ? 16 : 8));
  endfunction

  // Sends one pixel, then checks the whole line waveform, ready staying low
  // until exp_done cycles after accept, and the number of long pulses.
  task automatic run_pixel(input logic [23:0] d, input logic l, input int exp_ones,
                           input int exp_done, input string nm);
    int   n, mism, rdy_hi, ones;
    logic s_led[$];
    n = 0;
    valid = 1'b1; data_in = d; latch = l;
    while (!ready && n < 20000) begin tick(); n++; end
    if (!ready) begin
      chk({nm, " accept timeout"}, 0, 1);
      valid = 1'b0;
      return;
    end
    tick();
    mism = 0; rdy_hi = 0;
    for (int j = 0; j < exp_done; j++) begin
      s_led.push_back(led);
      if (led !== model_led(d, j)) mism++;
      if (ready !== 1'b0) rdy_hi++;
      // noise on the inputs while busy must be ignored
      valid   = (j < exp_done - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      data_in = 24'($urandom);
      latch   = 1'($urandom_range(0, 1));
      tick();
    end
    chk({nm, " waveform mismatches"}, mism, 0);
    chk({nm, " ready high while busy"}, rdy_hi, 0);
    chk({nm, " ready after pixel"}, int'(ready), 1);
    ones = 0;
    for (int i = 0; i < 24; i++) begin
      last_w[i] = 0;
      for (int k = 0; k < 25; k++) last_w[i] += int'(s_led[25*i+k]);
      if (last_w[i] == 16) ones++;
    end
    chk({nm, " long pulses"}, ones, exp_ones);
  endtask

`ifdef WS2812B_DOUBLE_BUFFER_EN
  logic [23:0] sp[4];

  function automatic logic db_model(input int j);
    if (j < 1800) return model_led(sp[j/600], j % 600);
    if (j < 7800) return 1'b0;
    if (j < 8400) return model_led(sp[3], j - 7800);
    return 1'b0;
  endfunction

  // Four pixels offered back to back, latch on the third: the first three
  // must be gapless, the fourth must start right after the latch period.
  task automatic run_stream(input string nm);
    int   k, mism, bad, gap;
    logic acc;
    logic s[$];
    int   rises[$];
    k = 0;
    for (int c = 0; c < 8500; c++) begin
      valid   = (k < 4);
      data_in = sp[(k < 4) ? k : 3];
      latch   = (k == 2);
      acc     = valid && ready;
      tick();
      if (acc) k++;
      s.push_back(led);
    end
    valid = 1'b0;
    mism = 0;
    for (int c = 0; c < 8500; c++) begin
      if (s[c] !== db_model(c)) mism++;
      if (s[c] && (c == 0 || !s[c-1])) rises.push_back(c);
    end
    chk({nm, " accepts"}, k, 4);
    chk({nm, " waveform mismatches"}, mism, 0);
    chk({nm, " rising edges"}, rises.size(), 96);
    bad = 0;
    for (int i = 1; i < 72 && i < rises.size(); i++)
      if (rises[i] - rises[i-1] != 25) bad++;
    chk({nm, " gapless spacing errors"}, bad, 0);
    gap = (rises.size() >= 73) ? rises[72] - rises[71] : -1;
    chk({nm, " latch gap"}, gap, 6025);
  endtask
`endif

  typedef struct {
    logic [23:0] data;
    logic        latch;
    int          exp_ones;
    int          exp_done;
  } vec_t;

  initial begin
    vec_t vt[5];
    int   a5w[8];
    int   n, hi, mism, acc_n, phases, rises;
    logic prev_rdy, prev_led;

    vt[0] = '{24'hA50000, 1'b0, 4, 600};
    vt[1] = '{24'hFFFFFF, 1'b1, 24, 6600};
    vt[2] = '{24'h000000, 1'b0, 0, 600};
    vt[3] = '{24'h800001, 1'b0, 2, 600};
    vt[4] = '{24'h0F0F0F, 1'b1, 12, 6600};
    a5w   = '{16, 8, 16, 8, 8, 16, 8, 16};

    repeat (3) tick();
    chk("led in reset", int'(led), 0);
    chk("ready in reset", int'(ready), 0);
    reset = 1'b0;

`ifndef WS2812B_DOUBLE_BUFFER_EN
    n = 0; hi = 0;
    while (!ready && n < 10000) begin tick(); n++; if (led) hi++; end
    chk("startup latch length", n, 6000);
    chk("led during startup latch", hi, 0);

    for (int i = 0; i < 5; i++) begin
      run_pixel(vt[i].data, vt[i].latch, vt[i].exp_ones, vt[i].exp_done,
                $sformatf("vec%0d", i));
      if (i == 0) begin
        mism = 0;
        for (int b = 0; b < 24; b++)
          if (last_w[b] != ((b < 8) ? a5w[b] : 8)) mism++;
        chk("A50000 pulse widths", mism, 0);
      end
    end

    // valid held high across ready's fall: one pixel per ready phase
    valid = 1'b1; data_in = 24'h00FF00; latch = 1'b0;
    acc_n = 0; rises = 0;
    phases = ready ? 1 : 0;
    prev_rdy = ready; prev_led = led;
    for (int c = 0; c < 3000; c++) begin
      if (valid && ready) acc_n++;
      tick();
      if (ready && !prev_rdy) phases++;
      if (led && !prev_led) rises++;
      prev_rdy = ready; prev_led = led;
    end
    valid = 1'b0;
    n = 0;
    while (!ready && n < 1000) begin
      tick(); n++;
      if (led && !prev_led) rises++;
      prev_led = led;
    end
    chk("held valid accepts", acc_n, 5);
    chk("held valid accepts per ready phase", acc_n, phases);
    chk("held valid rising edges", rises, 120);

    // reset in the middle of a pixel, while the line is high
    valid = 1'b1; data_in = 24'hFFFFFF; latch = 1'b0;
    n = 0;
    while (!ready && n < 1000) begin tick(); n++; end
    tick();
    valid = 1'b0;
    repeat (305) tick();
    chk("led high before mid-pixel reset", int'(led), 1);
    reset = 1'b1;
    #1;
    chk("led cleared by async reset", int'(led), 0);
    chk("ready cleared by async reset", int'(ready), 0);
    tick(); tick();
    reset = 1'b0;
    n = 0; hi = 0;
    while (!ready && n < 10000) begin tick(); n++; if (led) hi++; end
    chk("latch length after mid-pixel reset", n, 6000);
    chk("led during latch after mid-pixel reset", hi, 0);

    for (int i = 0; i < 15; i++) begin
      logic [23:0] d;
      logic        l;
      d = 24'($urandom);
      l = (i == 7);
      repeat ($urandom_range(0, 3)) tick();
      run_pixel(d, l, $countones(d), l ? 6600 : 600, $sformatf("rnd%0d", i));
    end
`else
    hi = 0;
    for (int c = 0; c < 6100; c++) begin tick(); if (led) hi++; end
    chk("led during startup latch", hi, 0);
    chk("ready after startup", int'(ready), 1);

    sp[0] = 24'hA50000; sp[1] = 24'hFFFFFF; sp[2] = 24'h0F0F0F; sp[3] = 24'h800000;
    run_stream("stream fixed");
    for (int i = 0; i < 4; i++) sp[i] = 24'($urandom);
    run_stream("stream random");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
